// File: rtl/chacha_aead_sequencer.sv
// Command/stream sequencer in front of chacha20_poly1305_core: packs 128-bit words into 512-bit blocks,
// drives init/next/done, unpacks results and holds the tag. Optional perf counters: CHACHA_SEQ_PERF_EN.
module chacha_aead_sequencer #(
  parameter int TIMEOUT = 1024,
  parameter int TCW     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_start,
  input  logic         cmd_encdec,
  input  logic [255:0] cmd_key,
  input  logic [95:0]  cmd_nonce,
  output logic         busy,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         tag_valid,
  output logic [127:0] tag_out,
  output logic         err,
  output logic         core_init,
  output logic         core_next,
  output logic         core_done,
  output logic         core_encdec,
  output logic [255:0] core_key,
  output logic [95:0]  core_nonce,
  output logic [511:0] core_data_in,
  input  logic         core_ready,
  input  logic         core_valid,
  input  logic         core_tag_ok,
  input  logic [511:0] core_data_out,
  input  logic [127:0] core_tag,
`ifdef CHACHA_SEQ_PERF_EN
  output logic [15:0]  perf_blocks,
  output logic [31:0]  perf_cycles,
`endif
  output logic [2:0]   state_dbg
);

  // Handshakes: a word moves on in_valid & in_ready, and on out_valid & out_ready;
  // out_valid/out_data hold steady until accepted.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_FILL     = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT     = 3'd4,
    S_DRAIN    = 3'd5,
    S_FINAL    = 3'd6,
    S_WAIT_TAG = 3'd7
  } state_t;

  state_t         state, state_nxt;
  logic [TCW-1:0] tmo_cnt;
  logic [1:0]     wcnt;
  logic [2:0]     nwords;
  logic           last_flag;
  logic [1:0]     lane;
  logic [511:0]   res_buf;
  logic           accept;
  logic           tmo_hit;
  logic           tmo_abort;
  logic           drain_end;

  assign accept    = in_valid && (state == S_FILL);
  assign tmo_hit   = (tmo_cnt == TCW'(TIMEOUT - 1));
  assign drain_end = out_ready && ({1'b0, lane} == (nwords - 3'd1));

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo_abort = 1'b0;
    case (state)
      S_IDLE:   if (cmd_start) state_nxt = S_INIT;
      S_INIT: begin
        if (core_ready) state_nxt = S_FILL;
        else if (tmo_hit) begin
          state_nxt = S_IDLE;
          tmo_abort = 1'b1;
        end
      end
      S_FILL:   if (accept && (wcnt == 2'd3 || in_last)) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_valid) state_nxt = S_DRAIN;
        else if (tmo_hit) begin
          state_nxt = S_IDLE;
          tmo_abort = 1'b1;
        end
      end
      S_DRAIN:  if (drain_end) state_nxt = last_flag ? S_FINAL : S_FILL;
      S_FINAL:  state_nxt = S_WAIT_TAG;
      S_WAIT_TAG: begin
        if (core_tag_ok) state_nxt = S_IDLE;
        else if (tmo_hit) begin
          state_nxt = S_IDLE;
          tmo_abort = 1'b1;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    in_ready  = (state == S_FILL);
    out_valid = (state == S_DRAIN);
    out_data  = (state == S_DRAIN) ? res_buf[{lane, 7'd0} +: 128] : 128'd0;
    core_next = (state == S_ISSUE);
    core_done = (state == S_FINAL);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      core_init    <= 1'b0;
      err          <= 1'b0;
      tmo_cnt      <= '0;
      core_encdec  <= 1'b0;
      core_key     <= '0;
      core_nonce   <= '0;
      core_data_in <= '0;
      wcnt         <= '0;
      nwords       <= '0;
      last_flag    <= 1'b0;
      lane         <= '0;
      res_buf      <= '0;
      tag_valid    <= 1'b0;
      tag_out      <= '0;
    end else begin
      core_init <= (state == S_IDLE) && cmd_start;
      err       <= tmo_abort;
      // Timeout counter restarts whenever a new state is entered.
      if (state_nxt != state)
        tmo_cnt <= '0;
      else if (state == S_INIT || state == S_WAIT || state == S_WAIT_TAG)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_IDLE && cmd_start) begin
        core_encdec <= cmd_encdec;
        core_key    <= cmd_key;
        core_nonce  <= cmd_nonce;
        tag_valid   <= 1'b0;
      end
      // Entering FILL starts a fresh block so short blocks carry zero lanes.
      if (state != S_FILL && state_nxt == S_FILL) begin
        core_data_in <= '0;
        wcnt         <= '0;
      end else if (accept) begin
        core_data_in[{wcnt, 7'd0} +: 128] <= in_data;
        wcnt      <= wcnt + 1'b1;
        nwords    <= {1'b0, wcnt} + 3'd1;
        last_flag <= in_last;
      end
      if (state == S_WAIT && core_valid) res_buf <= core_data_out;
      if (state != S_DRAIN && state_nxt == S_DRAIN) lane <= '0;
      else if (state == S_DRAIN && out_ready)       lane <= lane + 1'b1;
      if (state == S_WAIT_TAG && core_tag_ok) begin
        tag_out   <= core_tag;
        tag_valid <= 1'b1;
      end
    end
  end

`ifdef CHACHA_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_blocks <= '0;
      perf_cycles <= '0;
    end else if (state == S_IDLE && cmd_start) begin
      perf_blocks <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == S_ISSUE && perf_blocks != 16'hffff) perf_blocks <= perf_blocks + 1'b1;
      if (busy && perf_cycles != 32'hffff_ffff)        perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: doc/chacha_aead_sequencer.md
Name: chacha_aead_sequencer

Overview:
Command and stream sequencer in front of chacha20_poly1305_core. It accepts a key/nonce command and a 128-bit word stream. It packs the words into 512-bit blocks and drives the core's init/next/done pulses, then unpacks core output back into 128-bit words. The final tag is presented on a held output. It sits between the memory-side stream fabric and the AEAD core, so upstream logic never sees the core's block-level timing.

Parameters:
TIMEOUT, 1024, maximum cycles to wait for core_ready/core_valid/core_tag_ok before aborting (must be >= 2).
TCW, 11, width of the timeout counter (clog2(TIMEOUT)+1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
cmd_start  in  1  one-cycle command pulse; sampled only in IDLE
cmd_encdec  in  1  1=encrypt, 0=decrypt; latched on cmd_start
cmd_key  in  256  key, latched on cmd_start
cmd_nonce  in  96  nonce, latched on cmd_start
busy  out  1  high in every state except IDLE
in_valid  in  1  input word valid
in_data  in  128  input word
in_last  in  1  marks the last word of the message
in_ready  out  1  high only in FILL
out_valid  out  1  output word valid; held until out_ready
out_data  out  128  output word
out_ready  in  1  downstream accept
tag_valid  out  1  high from tag capture until the next cmd_start
tag_out  out  128  captured core tag
err  out  1  one-cycle pulse on timeout abort
core_init/core_next/core_done  out  1 each  one-cycle pulses to the core
core_encdec  out  1  latched encdec
core_key  out  256  latched key
core_nonce  out  96  latched nonce
core_data_in  out  512  packed block
core_ready/core_valid/core_tag_ok  in  1 each  core status
core_data_out  in  512  core result block
core_tag  in  128  core tag

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. All outputs 0, including core_data_in, key/nonce latches, counters and tag_out. Reset mid-operation abandons the message without any done pulse.
- IDLE: on cmd_start, latch key/nonce/encdec, clear tag_valid, pulse core_init for exactly 1 cycle, go to INIT.
- INIT: wait for core_ready=1, then go to FILL.
- FILL: in_ready=1. Each accepted word (in_valid & in_ready) is written to core_data_in[128*k+127 -: 128], with k = word count 0..3; k increments.
  - Go to ISSUE when k reaches 4, or when the accepted word has in_last=1.
  - Unfilled lanes are zero. They are cleared when FILL is entered.
  - nwords (1..4) is recorded for the block, and last_flag is recorded.
- ISSUE: pulse core_next for 1 cycle, go to WAIT.
- WAIT: on core_valid=1, capture core_data_out into an internal 512-bit buffer and go to DRAIN.
- DRAIN: present lanes 0..nwords-1 in ascending order. out_valid stays high and out_data stays stable until out_ready=1. After the last lane, go to FILL if last_flag=0, or FINAL if last_flag=1. Lanes beyond nwords are never emitted.
- FINAL: pulse core_done for 1 cycle, go to WAIT_TAG.
- WAIT_TAG: on core_tag_ok=1, capture core_tag into tag_out, set tag_valid, return to IDLE.
- Timeout: in INIT, WAIT or WAIT_TAG, a counter reloads on state entry. If the awaited signal has not arrived after TIMEOUT cycles: pulse err, go to IDLE, leave tag_valid=0.
- cmd_start outside IDLE is ignored.
- Messages are at least one word long. in_data is ignored when in_ready=0.
- Latency, single 1-word message with an instantaneous core: cmd_start to core_init is 1 cycle. Word accept to core_next is 1 cycle. core_valid to out_valid is 1 cycle.
- core_key, core_nonce and core_encdec stay constant from cmd_start until the next cmd_start.

Optional Feature:
CHACHA_SEQ_PERF_EN:
- When defined, adds outputs perf_blocks[15:0] and perf_cycles[31:0], both reset to 0 and cleared on cmd_start.
  - perf_blocks counts core_next pulses.
  - perf_cycles counts cycles with busy=1. Both saturate at all-ones.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Encrypt, 4 words of 128'hcafebabedeadbeefcafebabedeadbeef, in_last on word 3.
   - Required: one core_init, one core_next, one core_done.
   - 4 out words equal to core_data_out lanes 0..3 in order.
   - tag_valid=1 with tag_out=core_tag, busy=0 afterwards.
2. Message of 6 words.
   - Required: two core_next pulses. The second block has lanes 2..3 = 0.
   - Exactly 6 out words; perf_blocks=2 when CHACHA_SEQ_PERF_EN is defined.
3. Backpressure: out_ready low for 5 cycles during DRAIN.
   - Required: out_valid stays high, out_data stays unchanged, no word is lost or duplicated.
4. Core model never asserts core_valid with TIMEOUT=16.
   - Required: err pulses once 16 cycles after entry to WAIT, state returns to IDLE, tag_valid=0.
5. rst=0 asserted during DRAIN.
   - Required: all outputs 0 next cycle, no core_done issued.
   - A new cmd_start then completes a 1-word message normally.
6. cmd_start pulsed again while busy with key 256'h0.
   - Required: ignored, and core_key keeps the original value.
